// File: rtl/lcd_timing_ctrl.sv
// Raster timing controller for an RGB565 parallel LCD: derives the pixel clock,
// syncs, DE and registered colour, and fetches pixels one period ahead.
module lcd_timing_ctrl #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter int CLK_DIV  = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic [15:0] pix_data,
    output logic        pix_req,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        frame_start,
    output logic        busy,
    output logic        lcd_clk,
    output logic        lcd_de,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic [4:0]  lcd_r,
    output logic [5:0]  lcd_g,
    output logic [4:0]  lcd_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [8:0]    V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]    HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [8:0]    V_ACT    = 9'(V_ACTIVE);
    localparam logic [8:0]    VS_BEGIN = 9'(V_ACTIVE + V_FP);
    localparam logic [8:0]    VS_END   = 9'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [DW-1:0]  div_reg, div_next;
    // h_reg/v_reg hold the position that the next pix_ce drives to the pins
    logic [9:0]     h_reg, h_adv;
    logic [8:0]     v_reg, v_adv;
    logic           pix_ce, at_origin, adv_active;
    logic           cur_de, cur_hs, cur_vs;

    logic           lcd_clk_reg, de_reg, hs_reg, vs_reg;
    logic [15:0]    rgb_reg;
    logic           pix_req_reg, frame_start_reg;
    logic [9:0]     pix_x_reg;
    logic [8:0]     pix_y_reg;

    assign pix_ce     = (state_reg != IDLE) && (div_reg == DIV_LAST);
    assign at_origin  = (h_reg == 10'd0) && (v_reg == 9'd0);
    assign cur_de     = (h_reg < H_ACT) && (v_reg < V_ACT);
    assign cur_hs     = !((h_reg >= HS_BEGIN) && (h_reg < HS_END));
    assign cur_vs     = !((v_reg >= VS_BEGIN) && (v_reg < VS_END));
    assign adv_active = (h_adv < H_ACT) && (v_adv < V_ACT);

    always_comb begin
        h_adv = h_reg + 10'd1;
        v_adv = v_reg;
        if (h_reg == H_LAST) begin
            h_adv = 10'd0;
            v_adv = (v_reg == V_LAST) ? 9'd0 : v_reg + 9'd1;
        end
    end

    // Stopping only completes on the pix_ce that would start a new frame,
    // so the last pixel of the frame still receives its full lcd_clk period.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (en) state_next = RUN;
            RUN:      if (!en) state_next = STOPPING;
            STOPPING: begin
                if (en)
                    state_next = RUN;
                else if (pix_ce && at_origin)
                    state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        div_next = '0;
        if ((state_reg != IDLE) && (state_next != IDLE) && (div_reg != DIV_LAST))
            div_next = div_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= IDLE;
            div_reg         <= '0;
            h_reg           <= 10'd0;
            v_reg           <= 9'd0;
            lcd_clk_reg     <= 1'b0;
            de_reg          <= 1'b0;
            hs_reg          <= 1'b1;
            vs_reg          <= 1'b1;
            rgb_reg         <= 16'd0;
            pix_req_reg     <= 1'b0;
            pix_x_reg       <= 10'd0;
            pix_y_reg       <= 9'd0;
            frame_start_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            div_reg         <= div_next;
            lcd_clk_reg     <= (div_next >= DIV_HALF);
            frame_start_reg <= 1'b0;
            if ((state_reg == IDLE) || (state_next == IDLE)) begin
                h_reg       <= 10'd0;
                v_reg       <= 9'd0;
                de_reg      <= 1'b0;
                hs_reg      <= 1'b1;
                vs_reg      <= 1'b1;
                rgb_reg     <= 16'd0;
                pix_req_reg <= en;
                pix_x_reg   <= 10'd0;
                pix_y_reg   <= 9'd0;
            end else if (pix_ce) begin
                de_reg          <= cur_de;
                hs_reg          <= cur_hs;
                vs_reg          <= cur_vs;
                rgb_reg         <= cur_de ? pix_data : 16'd0;
                frame_start_reg <= at_origin;
                h_reg           <= h_adv;
                v_reg           <= v_adv;
                pix_req_reg     <= adv_active;
                if (adv_active) begin
                    pix_x_reg <= h_adv;
                    pix_y_reg <= v_adv;
                end
            end
        end
    end

    assign busy        = (state_reg != IDLE);
    assign lcd_clk     = lcd_clk_reg;
    assign lcd_de      = de_reg;
    assign lcd_hsync   = hs_reg;
    assign lcd_vsync   = vs_reg;
    assign lcd_r       = rgb_reg[15:11];
    assign lcd_g       = rgb_reg[10:5];
    assign lcd_b       = rgb_reg[4:0];
    assign pix_req     = pix_req_reg;
    assign pix_x       = pix_x_reg;
    assign pix_y       = pix_y_reg;
    assign frame_start = frame_start_reg;

endmodule
